// File: rtl/mult_seq_ctrl.sv
// Sequenced 3x3 multiplier with binary-to-BCD conversion and seven-segment decode.
// A start request latches the operands; the registered result appears nine cycles later.
module mult_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       busy,
  output logic       done,
  output logic [5:0] product,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic [6:0] led_ten,
  output logic [6:0] led_one
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  a_q;
  logic [2:0]  b_q;
  logic [5:0]  acc_q;
  logic [1:0]  iter_q;
  logic [13:0] sh_q;
  logic [2:0]  step_q;
  logic        busy_q;
  logic        done_q;
  logic [5:0]  product_q;
  logic [3:0]  ten_q;
  logic [3:0]  one_q;
  logic [6:0]  led_ten_q;
  logic [6:0]  led_one_q;

  logic        mul_bit_d;
  logic [5:0]  acc_d;
  logic [3:0]  ten_adj_d;
  logic [3:0]  one_adj_d;
  logic [13:0] sh_d;

  // Active-low segment pattern {g..a}; digits above 9 blank the display.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Multiplier bit selected by the current shift-add iteration.
  always_comb begin
    case (iter_q)
      2'd0:    mul_bit_d = b_q[0];
      2'd1:    mul_bit_d = b_q[1];
      2'd2:    mul_bit_d = b_q[2];
      default: mul_bit_d = 1'b0;
    endcase
  end

  // Shift-add partial product accumulation.
  always_comb begin
    if (mul_bit_d) begin
      acc_d = acc_q + ({3'b000, a_q} << iter_q);
    end else begin
      acc_d = acc_q;
    end
  end

  // Double-dabble step: correct digit fields >= 5, then shift left.
  always_comb begin
    if (sh_q[13:10] >= 4'd5) begin
      ten_adj_d = sh_q[13:10] + 4'd3;
    end else begin
      ten_adj_d = sh_q[13:10];
    end
    if (sh_q[9:6] >= 4'd5) begin
      one_adj_d = sh_q[9:6] + 4'd3;
    end else begin
      one_adj_d = sh_q[9:6];
    end
    sh_d = {ten_adj_d[2:0], one_adj_d, sh_q[5:0], 1'b0};
  end

  // Control FSM with operand, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 3'd0;
      b_q       <= 3'd0;
      acc_q     <= 6'd0;
      iter_q    <= 2'd0;
      sh_q      <= 14'd0;
      step_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 6'd0;
      ten_q     <= 4'd0;
      one_q     <= 4'd0;
      led_ten_q <= 7'b1000000;
      led_one_q <= 7'b1000000;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= 6'd0;
            iter_q  <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          if (iter_q == 2'd2) begin
            sh_q    <= {8'd0, acc_d};
            step_q  <= 3'd0;
            state_q <= S_BCD;
          end else begin
            iter_q <= iter_q + 2'd1;
          end
        end
        S_BCD: begin
          sh_q <= sh_d;
          if (step_q == 3'd5) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_q;
            ten_q     <= sh_d[13:10];
            one_q     <= sh_d[9:6];
            led_ten_q <= seg7(sh_d[13:10]);
            led_one_q <= seg7(sh_d[9:6]);
            state_q   <= S_DONE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ten     = ten_q;
  assign one     = one_q;
  assign led_ten = led_ten_q;
  assign led_one = led_one_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table, scoreboard of expected
// results, and hand-written sequences for ignored start, mid-flight reset and held start.
module tb_mult_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [5:0] product;
  logic [3:0] ten;
  logic [3:0] one;
  logic [6:0] led_ten;
  logic [6:0] led_one;

  mult_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .ten(ten), .one(one),
    .led_ten(led_ten), .led_one(led_one)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] p;
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] lt;
    logic [6:0] lo;
    int         acc_cyc;
  } rec_t;

  rec_t   sb_q[$];
  rec_t   vec[5];
  rec_t   mon_e;
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic rec_t model(input int ia, input int ib);
    rec_t r;
    int p;
    p = ia * ib;
    r.a = ia[2:0];
    r.b = ib[2:0];
    r.p = p[5:0];
    r.t = 4'(p / 10);
    r.o = 4'(p % 10);
    r.lt = seg_ref(p / 10);
    r.lo = seg_ref(p % 10);
    r.acc_cyc = 0;
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done product=%0d expected=no_done (cycle %0d)", product, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("product", 32'(product), 32'(mon_e.p));
        chk("ten", 32'(ten), 32'(mon_e.t));
        chk("one", 32'(one), 32'(mon_e.o));
        chk("led_ten", 32'(led_ten), 32'(mon_e.lt));
        chk("led_one", 32'(led_one), 32'(mon_e.lo));
        chk("latency", 32'(cyc - mon_e.acc_cyc), 32'd9);
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // One accepted operation with per-cycle busy/done timing checks.
  task automatic do_op(input rec_t e);
    rec_t r;
    r = e;
    a = e.a;
    b = e.b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r.acc_cyc = cyc;
    sb_q.push_back(r);
    for (int i = 0; i < 9; i++) begin
      chk("busy_window", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    chk(nm, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_product"}, 32'(product), 32'd0);
    chk({tag, "_ten"}, 32'(ten), 32'd0);
    chk({tag, "_one"}, 32'(one), 32'd0);
    chk({tag, "_led_ten"}, 32'(led_ten), 32'(7'b1000000));
    chk({tag, "_led_one"}, 32'(led_one), 32'(7'b1000000));
  endtask

  initial begin
    rec_t r;
    int   d0;

    vec[0] = '{3'd7, 3'd7, 6'd49, 4'd4, 4'd9, 7'b0011001, 7'b0010000, 0};
    vec[1] = '{3'd0, 3'd0, 6'd0,  4'd0, 4'd0, 7'b1000000, 7'b1000000, 0};
    vec[2] = '{3'd7, 3'd0, 6'd0,  4'd0, 4'd0, 7'b1000000, 7'b1000000, 0};
    vec[3] = '{3'd2, 3'd5, 6'd10, 4'd1, 4'd0, 7'b1111001, 7'b1000000, 0};
    vec[4] = '{3'd5, 3'd5, 6'd25, 4'd2, 4'd5, 7'b0100100, 7'b0010010, 0};

    rst = 1'b1;
    start = 1'b0;
    a = 3'd0;
    b = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) do_op(vec[i]);

    // start during the sequence with new operands must be ignored
    a = 3'd3; b = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r = model(3, 3);
    r.acc_cyc = cyc;
    sb_q.push_back(r);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    a = 3'd7; b = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain("ignored_start_drain");
    repeat (15) @(posedge clk);
    #1;
    chk("ignored_start_single_done", 32'(done_cnt - d0), 32'd1);

    // reset mid-flight abandons the operation
    a = 3'd7; b = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_beats_start", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    d0 = done_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    do_op(model(1, 6));

    // start held high: back-to-back accepts from DONE
    a = 3'd6; b = 3'd7; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    r = model(6, 7);
    r.acc_cyc = cyc;
    sb_q.push_back(r);
    for (int n = 1; n < 3; n++) begin
      repeat (10) @(posedge clk);
      #1;
      r.acc_cyc = cyc;
      sb_q.push_back(r);
    end
    start = 1'b0;
    drain("held_start_drain");
    chk("held_start_done_count", 32'(done_cnt - d0), 32'd3);
    @(posedge clk); #1;

    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        do_op(model(ia, ib));
      end
    end
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
